// File: rtl/load_store_unit.sv
// RV64I load/store stage: turns an ALU effective address into one aligned
// doubleword access on a valid/ready data port, with lane steering and load extension.
module load_store_unit #(
  parameter int DATA_W = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [DATA_W-1:0]     req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  output logic                  stall,
  output logic                  done,
  output logic                  fault,
  output logic [DATA_W-1:0]     load_data,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [DATA_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [DATA_W/8-1:0]   mem_be,
  input  logic                  mem_ready,
  input  logic                  mem_rvalid,
  input  logic [DATA_W-1:0]     mem_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_R, DONE} state_t;

  state_t     state;
  state_t     state_next;
  logic [2:0] funct3_q;
  logic [2:0] offset_q;
  logic       launch;
  logic       capture;
  logic       illegal;

  function automatic logic is_illegal(input logic we, input logic [2:0] f3, input logic [2:0] a);
    logic bad_f3;
    logic mis;
    bad_f3 = we ? f3[2] : (f3 == 3'b111);
    case (f3[1:0])
      2'b00:   mis = 1'b0;
      2'b01:   mis = a[0];
      2'b10:   mis = (a[1:0] != 2'b00);
      default: mis = (a != 3'b000);
    endcase
    return bad_f3 | mis;
  endfunction

  function automatic logic [7:0] lane_be(input logic [1:0] sz, input logic [2:0] off);
    logic [7:0] m;
    case (sz)
      2'b00:   m = 8'h01;
      2'b01:   m = 8'h03;
      2'b10:   m = 8'h0F;
      default: m = 8'hFF;
    endcase
    return m << off;
  endfunction

  function automatic logic [63:0] lane_wdata(input logic [63:0] d, input logic [1:0] sz, input logic [2:0] off);
    logic [63:0] keep;
    case (sz)
      2'b00:   keep = 64'h0000_0000_0000_00FF;
      2'b01:   keep = 64'h0000_0000_0000_FFFF;
      2'b10:   keep = 64'h0000_0000_FFFF_FFFF;
      default: keep = 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
    return (d & keep) << {off, 3'b000};
  endfunction

  function automatic logic [63:0] extract(input logic [63:0] d, input logic [2:0] f3, input logic [2:0] off);
    logic [63:0] sh;
    logic [63:0] r;
    sh = d >> {off, 3'b000};
    case (f3)
      3'b000:  r = {{56{sh[7]}}, sh[7:0]};
      3'b001:  r = {{48{sh[15]}}, sh[15:0]};
      3'b010:  r = {{32{sh[31]}}, sh[31:0]};
      3'b100:  r = {56'd0, sh[7:0]};
      3'b101:  r = {48'd0, sh[15:0]};
      3'b110:  r = {32'd0, sh[31:0]};
      default: r = sh;
    endcase
    return r;
  endfunction

  assign illegal = is_illegal(req_we, req_funct3, req_addr[2:0]);
  assign stall   = ((state == IDLE) & req_valid) | (state == REQ) | (state == WAIT_R);

  // Next-state decode plus the launch/capture strobes for the register block.
  always_comb begin
    state_next = state;
    launch     = 1'b0;
    capture    = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid && illegal) begin
          state_next = DONE;
        end else if (req_valid) begin
          state_next = REQ;
          launch     = 1'b1;
        end else begin
          state_next = IDLE;
        end
      end
      REQ: begin
        if (mem_ready && mem_we) begin
          state_next = DONE;
        end else if (mem_ready && mem_rvalid) begin
          state_next = DONE;
          capture    = 1'b1;
        end else if (mem_ready) begin
          state_next = WAIT_R;
        end else begin
          state_next = REQ;
        end
      end
      WAIT_R: begin
        if (mem_rvalid) begin
          state_next = DONE;
          capture    = 1'b1;
        end else begin
          state_next = WAIT_R;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State, registered handshake outputs, request latch and load result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      done      <= 1'b0;
      fault     <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
      load_data <= '0;
      funct3_q  <= 3'b000;
      offset_q  <= 3'b000;
    end else begin
      state   <= state_next;
      done    <= (state_next == DONE);
      fault   <= (state == IDLE) && (state_next == DONE);
      mem_req <= (state_next == REQ);
      if (launch) begin
        mem_we    <= req_we;
        mem_addr  <= {req_addr[DATA_W-1:3], 3'b000};
        mem_be    <= req_we ? lane_be(req_funct3[1:0], req_addr[2:0]) : 8'h00;
        mem_wdata <= req_we ? lane_wdata(req_wdata, req_funct3[1:0], req_addr[2:0]) : 64'd0;
        funct3_q  <= req_funct3;
        offset_q  <= req_addr[2:0];
      end
      if (capture) begin
        load_data <= extract(mem_rdata, funct3_q, offset_q);
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: the driver queues hand-computed memory
// requests and completions; a negedge monitor compares them as the DUT presents them.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_we;
  logic [2:0]  req_funct3;
  logic [63:0] req_addr, req_wdata;
  logic        stall, done, fault;
  logic [63:0] load_data;
  logic        mem_req, mem_we;
  logic [63:0] mem_addr, mem_wdata;
  logic [7:0]  mem_be;
  logic        mem_ready, mem_rvalid;
  logic [63:0] mem_rdata;

  typedef struct {
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [7:0]  be;
  } req_t;

  typedef struct {
    logic        flt;
    logic [63:0] ldata;
  } rsp_t;

  req_t exp_req[$];
  rsp_t exp_rsp[$];
  req_t mr;
  rsp_t mp;
  int   n_pass = 0;
  int   n_total = 0;

  load_store_unit #(.DATA_W(64)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .stall(stall), .done(done), .fault(fault), .load_data(load_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, "_stall"}, 64'(stall), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_fault"}, 64'(fault), 64'd0);
    chk({tag, "_mem_req"}, 64'(mem_req), 64'd0);
    chk({tag, "_mem_we"}, 64'(mem_we), 64'd0);
    chk({tag, "_mem_addr"}, mem_addr, 64'd0);
    chk({tag, "_mem_wdata"}, mem_wdata, 64'd0);
    chk({tag, "_mem_be"}, 64'(mem_be), 64'd0);
    chk({tag, "_load_data"}, load_data, 64'd0);
  endtask

  // Monitor: compare every presented request and every completion against the queues.
  always @(negedge clk) begin
    if (!reset) begin
      if (mem_req) begin
        if (exp_req.size() == 0) begin
          chk("unexpected_mem_req", 64'(mem_req), 64'd0);
        end else begin
          mr = exp_req[0];
          chk("mem_we", 64'(mem_we), 64'(mr.we));
          chk("mem_addr", mem_addr, mr.addr);
          chk("mem_be", 64'(mem_be), 64'(mr.be));
          if (mr.we) chk("mem_wdata", mem_wdata, mr.wdata);
          if (mem_ready) void'(exp_req.pop_front());
        end
      end
      if (done) begin
        if (exp_rsp.size() == 0) begin
          chk("unexpected_done", 64'(done), 64'd0);
        end else begin
          mp = exp_rsp.pop_front();
          chk("fault", 64'(fault), 64'(mp.flt));
          chk("load_data", load_data, mp.ldata);
        end
      end
    end
  end

  task automatic do_access(input string name, input logic we, input logic [2:0] f3,
                           input logic [63:0] addr, input logic [63:0] wdata,
                           input int rdy_dly, input int rv_dly, input logic [63:0] rdata,
                           input logic exp_fault, input logic [63:0] exp_addr,
                           input logic [7:0] exp_be, input logic [63:0] exp_wdata,
                           input logic [63:0] exp_ldata, input int exp_cycle);
    int   cycle = 0;
    int   rq_cnt = 0;
    int   wcnt = 0;
    logic acc = 1'b0;
    logic finished = 1'b0;
    logic stall_ok = 1'b1;
    req_t r;
    rsp_t p;
    r.we = we; r.addr = exp_addr; r.wdata = exp_wdata; r.be = exp_be;
    p.flt = exp_fault; p.ldata = exp_ldata;
    if (!exp_fault) exp_req.push_back(r);
    exp_rsp.push_back(p);
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    mem_rdata = rdata;
    while (!finished && cycle < 60) begin
      mem_ready  = 1'b0;
      mem_rvalid = 1'b0;
      if (mem_req) begin
        mem_ready = (rq_cnt >= rdy_dly);
        rq_cnt++;
        if (mem_ready) begin
          acc = 1'b1;
          wcnt = 0;
          mem_rvalid = !we && (rv_dly == 0);
        end
      end else if (acc && !we) begin
        wcnt++;
        mem_rvalid = (wcnt == rv_dly);
      end
      #1;
      if (done) begin
        finished = 1'b1;
        if (stall) stall_ok = 1'b0;
        chk({name, "_done_cycle"}, 64'(cycle), 64'(exp_cycle));
      end else begin
        if (!stall) stall_ok = 1'b0;
        @(posedge clk); #1;
        cycle++;
      end
    end
    mem_ready  = 1'b0;
    mem_rvalid = 1'b0;
    chk({name, "_done_seen"}, 64'(finished), 64'd1);
    chk({name, "_stall_profile"}, 64'(stall_ok), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
    req_addr = 64'd0; req_wdata = 64'd0;
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = 64'd0;
    #12;
    check_cleared("reset");
    @(posedge clk); #1;
    reset = 1'b0;

    do_access("sd", 1'b1, 3'b011, 64'h1000, 64'h1122334455667788, 0, 0, 64'd0,
              1'b0, 64'h1000, 8'hFF, 64'h1122334455667788, 64'd0, 2);
    do_access("sb", 1'b1, 3'b000, 64'h1005, 64'h55667788990011AB, 3, 0, 64'd0,
              1'b0, 64'h1000, 8'h20, 64'h0000AB0000000000, 64'd0, 5);
    do_access("lb", 1'b0, 3'b000, 64'h2003, 64'd0, 0, 0, 64'h0000000080000000,
              1'b0, 64'h2000, 8'h00, 64'd0, 64'hFFFFFFFFFFFFFF80, 2);
    do_access("lbu", 1'b0, 3'b100, 64'h2003, 64'd0, 0, 0, 64'h0000000080000000,
              1'b0, 64'h2000, 8'h00, 64'd0, 64'h0000000000000080, 2);
    do_access("lw", 1'b0, 3'b010, 64'h2004, 64'd0, 0, 2, 64'h89ABCDEF00000000,
              1'b0, 64'h2000, 8'h00, 64'd0, 64'hFFFFFFFF89ABCDEF, 4);
    do_access("lwu", 1'b0, 3'b110, 64'h2004, 64'd0, 1, 0, 64'h89ABCDEF00000000,
              1'b0, 64'h2000, 8'h00, 64'd0, 64'h0000000089ABCDEF, 3);
    do_access("lh", 1'b0, 3'b001, 64'h2006, 64'd0, 0, 0, 64'h8001000000000000,
              1'b0, 64'h2000, 8'h00, 64'd0, 64'hFFFFFFFFFFFF8001, 2);
    do_access("lh_mis", 1'b0, 3'b001, 64'h3001, 64'd0, 0, 0, 64'd0,
              1'b1, 64'd0, 8'h00, 64'd0, 64'hFFFFFFFFFFFF8001, 1);
    do_access("sd_mis", 1'b1, 3'b011, 64'h3004, 64'hDEAD, 0, 0, 64'd0,
              1'b1, 64'd0, 8'h00, 64'd0, 64'hFFFFFFFFFFFF8001, 1);
    do_access("st_f3", 1'b1, 3'b100, 64'h3000, 64'hBEEF, 0, 0, 64'd0,
              1'b1, 64'd0, 8'h00, 64'd0, 64'hFFFFFFFFFFFF8001, 1);
    do_access("sh", 1'b1, 3'b001, 64'h3006, 64'hFFFFFFFFFFFF1234, 0, 0, 64'd0,
              1'b0, 64'h3000, 8'hC0, 64'h1234000000000000, 64'hFFFFFFFFFFFF8001, 2);
    do_access("sw", 1'b1, 3'b010, 64'h3004, 64'h11111111CAFEBABE, 1, 0, 64'd0,
              1'b0, 64'h3000, 8'hF0, 64'hCAFEBABE00000000, 64'hFFFFFFFFFFFF8001, 3);
    do_access("ld", 1'b0, 3'b011, 64'h3008, 64'd0, 2, 1, 64'h0123456789ABCDEF,
              1'b0, 64'h3008, 8'h00, 64'd0, 64'h0123456789ABCDEF, 5);

    // Abandon a load sitting in WAIT_R with an asynchronous reset.
    mr.we = 1'b0; mr.addr = 64'h4000; mr.wdata = 64'd0; mr.be = 8'h00;
    exp_req.push_back(mr);
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b011; req_addr = 64'h4000;
    @(posedge clk); #1;
    mem_ready = 1'b1;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    reset = 1'b1;
    req_valid = 1'b0;
    #1;
    check_cleared("mid_reset");
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    mem_rvalid = 1'b1; mem_rdata = 64'hFFFFFFFFFFFFFFFF;
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    #1;
    chk("stray_rvalid_done", 64'(done), 64'd0);
    chk("stray_rvalid_load_data", load_data, 64'd0);
    chk("stray_rvalid_stall", 64'(stall), 64'd0);

    do_access("ld_after_reset", 1'b0, 3'b011, 64'h4008, 64'd0, 0, 0, 64'hFEDCBA9876543210,
              1'b0, 64'h4008, 8'h00, 64'd0, 64'hFEDCBA9876543210, 2);

    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("req_queue_empty", 64'(exp_req.size()), 64'd0);
    chk("rsp_queue_empty", 64'(exp_rsp.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Multi-cycle memory-access stage directly downstream of the 64-bit ALU in the RV64I core. It takes the ALU result as the effective address of a load or store and drives a valid/ready data-memory port using 8-byte-aligned addresses and byte enables. It aligns and extends load data, stalls the core until the access completes, and flags misaligned or illegal accesses.

## Interface
- `DATA_W`, default 64: data and address width; fixed at 64 for RV64I.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `req_valid` in 1: current instruction is a load or store; held stable while `stall`=1.
- `req_we` in 1: 1 = store, 0 = load.
- `req_funct3` in 3: RISC-V funct3 (LB/LH/LW/LD/LBU/LHU/LWU; SB/SH/SW/SD).
- `req_addr` in 64: effective address (ALU result).
- `req_wdata` in 64: store data (rs2).
- `stall` out 1: freeze PC/pipeline while high.
- `done` out 1: one-cycle pulse; access finished; core advances this cycle.
- `fault` out 1: valid with `done`; misaligned address or illegal funct3, no memory access made.
- `load_data` out 64: aligned, extended load result; holds until next load completes.
- `mem_req` out 1: memory request valid.
- `mem_we` out 1: request is a write.
- `mem_addr` out 64: `{req_addr[63:3], 3'b000}`.
- `mem_wdata` out 64: store data shifted into lane position.
- `mem_be` out 8: byte enables; 0 for reads.
- `mem_ready` in 1: memory accepts the request when `mem_req`&`mem_ready`.
- `mem_rvalid` in 1: read data valid.
- `mem_rdata` in 64: read data, full doubleword.

## Operation
- FSM states: IDLE, REQ, WAIT_R, DONE.
- IDLE, `req_valid`=0: no action.
- IDLE, `req_valid`=1, request legal: register request, `mem_*` outputs, and offset `req_addr[2:0]`; go to REQ.
- IDLE, `req_valid`=1, request illegal: go to DONE with `fault`=1. `mem_req` is never raised.
- Illegal request, misaligned: H needs addr[0]=0, W needs addr[1:0]=0, D needs addr[2:0]=0.
- Illegal request, bad funct3: load funct3=111, or store funct3[2]=1.
- REQ: `mem_req`=1; all `mem_*` outputs held stable until `mem_ready`.
  - Accept on a store: go to DONE.
  - Accept on a load with `mem_rvalid`=0: go to WAIT_R.
  - Accept on a load with `mem_rvalid`=1 in the same cycle: capture data, go to DONE.
  - After accept, `mem_req` drops to 0.
- WAIT_R: on `mem_rvalid`, capture and go to DONE.
- DONE: `done`=1 for exactly one cycle, `stall`=0, then return to IDLE. No relaunch, even though `req_valid` is still high this cycle.
- `stall` = (IDLE & `req_valid`) | REQ | WAIT_R. This is the only combinational path from an input.
- Store lanes, with o = offset and size = 1/2/4/8 bytes:
  - `mem_be` = ((1<<size)-1) << o.
  - `mem_wdata` = low size bytes of `req_wdata` shifted left by 8*o; other bytes 0.
- Load: s = `mem_rdata` >> 8*o, then take the low size bytes.
  - Sign-extend for LB/LH/LW.
  - Zero-extend for LBU/LHU/LWU.
  - LD is taken as is.
- Ignored inputs: `mem_rvalid` outside REQ/WAIT_R, and any `mem_ready` when `mem_req`=0.

## Timing
- Reset (async assert, any state): state IDLE. `stall`, `done`, `fault`, `mem_req`, `mem_we` = 0; `mem_addr`, `mem_wdata`, `mem_be`, `load_data` = 0.
- Reset mid-access abandons the request. A late `mem_rvalid` after reset is ignored.
- Minimum latency, store with `mem_ready` tied 1: 3 cycles. Cycle 0 IDLE (stall), cycle 1 REQ (accepted), cycle 2 DONE.
- Minimum latency, load with ready and rvalid in the same cycle: 3 cycles.
- Each wait cycle on `mem_ready` or `mem_rvalid` adds one cycle.
- Fault path: 2 cycles (IDLE stall, then DONE with `fault`).
- `load_data` updates on the clock edge that enters DONE. It is valid while `done`=1 and thereafter.
- Back-to-back requests: a new request can be taken in the IDLE cycle right after DONE.

## Test plan
- SD: addr 0x1000, wdata 0x1122334455667788, `mem_ready`=1 -> `mem_addr`=0x1000, `mem_be`=0xFF, `mem_we`=1; `done` on cycle 2; `stall` high on cycles 0-1.
- SB: addr 0x1005, wdata 0xAB, ready delayed 3 cycles -> `mem_be`=0x20, `mem_wdata`=0x0000AB0000000000, request stable while waiting; `done` on cycle 5.
- LB at 0x2003 / LBU at 0x2003, rdata 0x00000000_80000000 with byte 3 = 0x80 -> `load_data` 0xFFFFFFFFFFFFFF80 / 0x80.
- LW at 0x2004, rdata 0x89ABCDEF_00000000, rvalid 2 cycles after accept -> `load_data` 0xFFFFFFFF89ABCDEF. LWU at the same address -> 0x0000000089ABCDEF.
- LH at 0x3001 and SD at 0x3004 -> `fault`=1 with `done` on cycle 1; `mem_req` never asserted. Store with funct3=100 -> `fault`.
- Load in WAIT_R, assert `reset` -> all outputs 0, state IDLE. A subsequent stray `mem_rvalid` has no effect. The next LD completes normally.
